// File: rtl/rename_pkg.sv
// Constants and types shared by the rename register file and the rename free queue:
// default physical-name width, queue depth/pointer width, the entry record and queue-op codes.
package rename_pkg;

    localparam int NAME_WIDTH = 1;
    localparam int DEPTH      = 4;
    localparam int PTR_WIDTH  = 2;

    typedef struct packed {
        logic [NAME_WIDTH-1:0] name;
        logic                  done;
    } rename_entry_t;

    // Bit 1 = commit accepted, bit 0 = enqueue accepted.
    typedef enum logic [1:0] {
        Q_IDLE   = 2'b00,
        Q_ENQ    = 2'b01,
        Q_COMMIT = 2'b10,
        Q_BOTH   = 2'b11
    } q_op_e;

endpackage

// File: rtl/rename_wb_match.sv
// Compares a writeback name against every queue entry; a hit needs the strobe and a valid entry.
module rename_wb_match #(
    parameter int name_width = 1,
    parameter int depth      = 4
) (
    input  logic [name_width-1:0]            wb_name,
    input  logic                             wb_e,
    input  logic [depth-1:0]                 valid,
    input  logic [depth-1:0][name_width-1:0] names,
    output logic [depth-1:0]                 hit
);

    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_cmp
            assign hit[gi] = wb_e && valid[gi] && (names[gi] == wb_name);
        end
    endgenerate

endmodule

// File: rtl/rename_free_queue.sv
// In-order commit queue behind the rename file: tracks allocated names, marks them done on
// writeback and frees them in order. Define RENAME_FREE_QUEUE_AUTO_EN to commit without COMMIT_E.
module rename_free_queue
    import rename_pkg::*;
#(
    parameter int name_width = NAME_WIDTH,
    parameter int depth      = DEPTH,
    parameter int ptr_width  = PTR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [name_width-1:0] ENQ_NAME,
    input  logic                  ENQ_E,
    output logic                  ENQ_READY,
    input  logic [name_width-1:0] WB_NAME,
    input  logic                  WB_E,
    input  logic                  COMMIT_E,
    output logic                  COMMIT_READY,
    output logic [name_width-1:0] NAME_F,
    output logic                  FE,
    output logic [ptr_width:0]    COUNT
);

    localparam logic [ptr_width:0]   FULL_COUNT = (ptr_width+1)'(depth);
    localparam logic [ptr_width:0]   COUNT_ONE  = (ptr_width+1)'(1);
    localparam logic [ptr_width-1:0] PTR_ONE    = ptr_width'(1);

    typedef struct packed {
        logic [name_width-1:0] name;
        logic                  done;
    } entry_t;

    entry_t [depth-1:0]               entry_reg;
    logic   [depth-1:0]               valid_reg;
    logic   [ptr_width-1:0]           head_reg;
    logic   [ptr_width-1:0]           tail_reg;
    logic   [ptr_width:0]             count_reg;
    logic                             fe_reg;
    logic   [name_width-1:0]          name_f_reg;

    logic   [depth-1:0][name_width-1:0] entry_names;
    logic   [depth-1:0]               wb_hit;
    logic                             enq_fire;
    logic                             commit_req;
    logic                             commit_fire;
    logic                             enq_wb_same;
    q_op_e                            q_op;

    assign ENQ_READY    = (count_reg < FULL_COUNT);
    assign COMMIT_READY = valid_reg[head_reg] && entry_reg[head_reg].done;

`ifdef RENAME_FREE_QUEUE_AUTO_EN
    assign commit_req = 1'b1;
`else
    assign commit_req = COMMIT_E;
`endif

    assign enq_fire    = ENQ_E && ENQ_READY;
    assign commit_fire = commit_req && COMMIT_READY;
    // A name written back while it is being enqueued must not lose its done bit.
    assign enq_wb_same = WB_E && (WB_NAME == ENQ_NAME);
    assign q_op        = q_op_e'({commit_fire, enq_fire});

    rename_wb_match #(
        .name_width (name_width),
        .depth      (depth)
    ) u_wb_match (
        .wb_name (WB_NAME),
        .wb_e    (WB_E),
        .valid   (valid_reg),
        .names   (entry_names),
        .hit     (wb_hit)
    );

    // When not full, tail never aliases a valid head, so enqueue and commit never share a slot.
    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_entry
            localparam logic [ptr_width-1:0] IDX = ptr_width'(gi);

            assign entry_names[gi] = entry_reg[gi].name;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    valid_reg[gi] <= 1'b0;
                    entry_reg[gi] <= '0;
                end else if (enq_fire && (tail_reg == IDX)) begin
                    valid_reg[gi]      <= 1'b1;
                    entry_reg[gi].name <= ENQ_NAME;
                    entry_reg[gi].done <= enq_wb_same;
                end else begin
                    if (commit_fire && (head_reg == IDX)) begin
                        valid_reg[gi] <= 1'b0;
                    end
                    if (wb_hit[gi]) begin
                        entry_reg[gi].done <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (enq_fire) begin
                tail_reg <= tail_reg + PTR_ONE;
            end
            if (commit_fire) begin
                head_reg <= head_reg + PTR_ONE;
            end
            case (q_op)
                Q_ENQ:    count_reg <= count_reg + COUNT_ONE;
                Q_COMMIT: count_reg <= count_reg - COUNT_ONE;
                default:  count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fe_reg     <= 1'b0;
            name_f_reg <= '0;
        end else begin
            fe_reg <= commit_fire;
            if (commit_fire) begin
                name_f_reg <= entry_reg[head_reg].name;
            end
        end
    end

    assign FE     = fe_reg;
    assign NAME_F = name_f_reg;
    assign COUNT  = count_reg;

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST && ENQ_E && !ENQ_READY) begin
            $display("rename_free_queue: ENQ_E while full ignored at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_rename_free_queue.sv
// Bench for rename_free_queue (depth 4, 3-bit names): directed scenarios plus random traffic
// checked against a queue-based model of the commit queue.
module tb_rename_free_queue;

    logic       clk;
    logic       rst;
    logic [2:0] enq_name;
    logic       enq_e;
    logic       enq_ready;
    logic [2:0] wb_name;
    logic       wb_e;
    logic       commit_e;
    logic       commit_ready;
    logic [2:0] name_f;
    logic       fe;
    logic [2:0] count;

    rename_free_queue #(
        .name_width (3),
        .depth      (4),
        .ptr_width  (2)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .ENQ_NAME     (enq_name),
        .ENQ_E        (enq_e),
        .ENQ_READY    (enq_ready),
        .WB_NAME      (wb_name),
        .WB_E         (wb_e),
        .COMMIT_E     (commit_e),
        .COMMIT_READY (commit_ready),
        .NAME_F       (name_f),
        .FE           (fe),
        .COUNT        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] name;
        bit         done;
    } mdl_entry_t;

    mdl_entry_t  mdl_q[$];
    bit          exp_fe;
    logic [2:0]  exp_name_f;
    int          vec_cnt;
    int          err_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_q(input logic [2:0] n);
        foreach (mdl_q[i]) if (mdl_q[i].name == n) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a negedge: check state-derived outputs, apply one cycle of inputs, advance the model.
    task automatic step(input bit rst_i, input bit enq_e_i, input logic [2:0] enq_name_i,
                        input bit wb_e_i, input logic [2:0] wb_name_i, input bit commit_e_i);
        bit head_ready;
        bit do_commit;
        bit do_enq;
        head_ready = (mdl_q.size() > 0) && mdl_q[0].done;
        check("count", 32'(count), 32'(mdl_q.size()));
        check("enq_ready", 32'(enq_ready), 32'(mdl_q.size() < 4));
        check("commit_ready", 32'(commit_ready), 32'(head_ready));
        check("fe", 32'(fe), 32'(exp_fe));
        check("name_f", 32'(name_f), 32'(exp_name_f));

        rst      = rst_i;
        enq_e    = enq_e_i;
        enq_name = enq_name_i;
        wb_e     = wb_e_i;
        wb_name  = wb_name_i;
        commit_e = commit_e_i;
        @(posedge clk);

        if (rst_i) begin
            mdl_q.delete();
            exp_fe     = 1'b0;
            exp_name_f = '0;
        end else begin
`ifdef RENAME_FREE_QUEUE_AUTO_EN
            do_commit = head_ready;
`else
            do_commit = commit_e_i && head_ready;
`endif
            do_enq = enq_e_i && (mdl_q.size() < 4);
            if (wb_e_i) begin
                foreach (mdl_q[i]) if (mdl_q[i].name == wb_name_i) mdl_q[i].done = 1'b1;
            end
            exp_fe = do_commit;
            if (do_commit) begin
                exp_name_f = mdl_q[0].name;
                void'(mdl_q.pop_front());
            end
            if (do_enq) begin
                mdl_q.push_back('{name: enq_name_i, done: (wb_e_i && (wb_name_i == enq_name_i))});
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic enq(input logic [2:0] n);
        step(1'b0, 1'b1, n, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic wb(input logic [2:0] n, input bit c);
        step(1'b0, 1'b0, 3'd0, 1'b1, n, c);
    endtask

    task automatic idle(input bit c);
        step(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, c);
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        exp_fe     = 1'b0;
        exp_name_f = '0;
        rst        = 1'b1;
        enq_e      = 1'b0;
        enq_name   = '0;
        wb_e       = 1'b0;
        wb_name    = '0;
        commit_e   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Fill to full, then a dropped fifth enqueue.
        do_reset();
        for (int n = 4; n < 8; n++) enq(3'(n));
        enq(3'd3);
        idle(1'b0);

        // Out-of-order writeback with COMMIT_E held high.
        do_reset();
        enq(3'd4);
        enq(3'd5);
        wb(3'd5, 1'b1);
        wb(3'd4, 1'b1);
        repeat (3) idle(1'b1);

        // Full queue: commit and enqueue together, enqueue refused.
        do_reset();
        for (int n = 4; n < 8; n++) enq(3'(n));
        wb(3'd4, 1'b0);
        step(1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1);
        idle(1'b0);

        // Wrap-around over ten rounds.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            for (int n = 4; n < 8; n++) begin
                enq(3'(n));
                wb(3'(n), 1'b0);
                idle(1'b1);
            end
        end
        idle(1'b0);

        // Writeback in the same cycle as the enqueue of that name.
        do_reset();
        step(1'b0, 1'b1, 3'd6, 1'b1, 3'd6, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Reset in the cycle a commit is accepted.
        do_reset();
        enq(3'd1);
        wb(3'd1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        idle(1'b0);

        // Random traffic, names kept unique while the queue can accept them.
        for (int k = 0; k < 400; k++) begin
            bit         r_rst;
            bit         r_enq;
            bit         r_wb;
            bit         r_com;
            logic [2:0] r_name;
            logic [2:0] r_wbn;
            r_rst  = ($urandom_range(0, 59) == 0);
            r_name = 3'($urandom_range(0, 7));
            r_enq  = ($urandom_range(0, 2) != 0);
            if (r_enq && (mdl_q.size() < 4) && in_q(r_name)) r_enq = 1'b0;
            r_wb   = ($urandom_range(0, 1) == 1);
            r_wbn  = (r_wb && (mdl_q.size() > 0) && ($urandom_range(0, 3) != 0))
                     ? mdl_q[$urandom_range(0, mdl_q.size() - 1)].name
                     : 3'($urandom_range(0, 7));
            r_com  = ($urandom_range(0, 2) != 0);
            step(r_rst, r_enq, r_name, r_wb, r_wbn, r_com);
        end
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
